// File: rtl/rectangle_pkg.sv
// Shared constants, S-box tables, state encoding and the row-shift helper for
// the RECTANGLE decryption core.
package rectangle_pkg;

    localparam int DEFAULT_ROUNDS = 25;

    // Rotation amounts that undo the encryption ShiftRow (rotl 1/12/13).
    localparam int ROW1_SHIFT = 1;
    localparam int ROW2_SHIFT = 12;
    localparam int ROW3_SHIFT = 13;

    localparam logic [3:0] INV_SBOX [16] = '{
        4'h9, 4'h4, 4'hF, 4'hA, 4'hE, 4'h1, 4'h0, 4'h6,
        4'hC, 4'h7, 4'h3, 4'h8, 4'h2, 4'hB, 4'h5, 4'hD
    };

    localparam logic [3:0] SBOX [16] = '{
        4'h6, 4'h5, 4'hC, 4'hA, 4'h1, 4'hE, 4'h7, 4'h9,
        4'hB, 4'h0, 4'h3, 4'hD, 4'h8, 4'hF, 4'h4, 4'h2
    };

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } dec_state_e;

    function automatic logic [15:0] rotr16(input logic [15:0] x, input int unsigned r);
        return (x >> r) | (x << (16 - r));
    endfunction

    function automatic logic [63:0] inv_shift_row(input logic [63:0] s);
        return {rotr16(s[63:48], ROW3_SHIFT),
                rotr16(s[47:32], ROW2_SHIFT),
                rotr16(s[31:16], ROW1_SHIFT),
                s[15:0]};
    endfunction

endpackage

// File: rtl/sbox_inv.sv
// 4-bit combinational RECTANGLE inverse S-box (one column nibble, row0 = LSB).
module sbox_inv
    import rectangle_pkg::*;
(
    input  logic [3:0] din,
    output logic [3:0] dout
);

    assign dout = INV_SBOX[din];

endmodule

// File: rtl/rectangle_dec_core.sv
// Iterative RECTANGLE decryption: one inverse round per clock, keys fetched by index.
// Optional macro RECT_DEC_FLUSH_EN adds an i_flush input that aborts any operation.
module rectangle_dec_core
    import rectangle_pkg::*;
#(
    parameter int ROUNDS = DEFAULT_ROUNDS,
    parameter int IDX_W  = 5
) (
    input  logic             clk,
    input  logic             rst_n,
`ifdef RECT_DEC_FLUSH_EN
    input  logic             i_flush,
`endif
    input  logic             i_s_valid,
    output logic             o_s_ready,
    input  logic [63:0]      iv_ct,
    output logic [IDX_W-1:0] ov_rk_idx,
    input  logic [63:0]      iv_rk,
    output logic             o_m_valid,
    input  logic             i_m_ready,
    output logic [63:0]      ov_pt
);

    dec_state_e       state_reg, state_next;
    logic [IDX_W-1:0] cnt_reg, cnt_next;
    logic [63:0]      blk_reg, blk_next;
    logic [63:0]      pt_reg, pt_next;

    logic [63:0]      shifted;
    logic [63:0]      sub_out;
    logic [63:0]      round_out;
    logic [3:0]       sub_col [16];

    assign shifted = inv_shift_row(blk_reg);

    // Each column gathers one bit from every row; the substituted nibble is
    // scattered back to the same bit position of each row.
    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_col
            sbox_inv u_sbox_inv (
                .din  ({shifted[48+gi], shifted[32+gi], shifted[16+gi], shifted[gi]}),
                .dout (sub_col[gi])
            );
            assign sub_out[gi]    = sub_col[gi][0];
            assign sub_out[16+gi] = sub_col[gi][1];
            assign sub_out[32+gi] = sub_col[gi][2];
            assign sub_out[48+gi] = sub_col[gi][3];
        end
    endgenerate

    assign round_out = sub_out ^ iv_rk;

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        blk_next   = blk_reg;
        pt_next    = pt_reg;
        case (state_reg)
            IDLE: begin
                if (i_s_valid) begin
                    blk_next   = iv_ct ^ iv_rk;
                    cnt_next   = IDX_W'(ROUNDS - 1);
                    state_next = ROUND;
                end
            end
            ROUND: begin
                blk_next = round_out;
                if (cnt_reg == '0) begin
                    pt_next    = round_out;
                    state_next = DONE;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            DONE: begin
                if (i_m_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
`ifdef RECT_DEC_FLUSH_EN
        // Flush wins over everything; an in-flight result never reaches ov_pt.
        if (i_flush) begin
            state_next = IDLE;
            cnt_next   = '0;
            pt_next    = pt_reg;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            blk_reg   <= '0;
            pt_reg    <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            blk_reg   <= blk_next;
            pt_reg    <= pt_next;
        end
    end

    always_comb begin
        o_s_ready = 1'b0;
        o_m_valid = 1'b0;
        ov_rk_idx = '0;
        case (state_reg)
            IDLE: begin
                o_s_ready = 1'b1;
                ov_rk_idx = IDX_W'(ROUNDS);
            end
            ROUND: begin
                ov_rk_idx = cnt_reg;
            end
            DONE: begin
                o_m_valid = 1'b1;
            end
            default: begin
                ov_rk_idx = '0;
            end
        endcase
    end

    assign ov_pt = pt_reg;

endmodule

// File: tb/tb_rectangle_dec_core.sv
// Bench for rectangle_dec_core: unit 0 built with ROUNDS=1, unit 1 with ROUNDS=25,
// each fed by a combinational key store and checked against a forward-cipher model.
module tb_rectangle_dec_core;
    import rectangle_pkg::*;

    localparam int IDX_W = 5;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             s_valid [2];
    logic             s_ready [2];
    logic [63:0]      ct      [2];
    logic [IDX_W-1:0] rk_idx  [2];
    logic [63:0]      rk      [2];
    logic             m_valid [2];
    logic             m_ready [2];
    logic [63:0]      pt      [2];
`ifdef RECT_DEC_FLUSH_EN
    logic             flush   [2];
`endif
    logic [63:0]      keys    [2][32];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_dut
            localparam int R = (gi == 0) ? 1 : 25;
            assign rk[gi] = keys[gi][rk_idx[gi]];
            rectangle_dec_core #(.ROUNDS(R), .IDX_W(IDX_W)) dut (
                .clk       (clk),
                .rst_n     (rst_n),
`ifdef RECT_DEC_FLUSH_EN
                .i_flush   (flush[gi]),
`endif
                .i_s_valid (s_valid[gi]),
                .o_s_ready (s_ready[gi]),
                .iv_ct     (ct[gi]),
                .ov_rk_idx (rk_idx[gi]),
                .iv_rk     (rk[gi]),
                .o_m_valid (m_valid[gi]),
                .i_m_ready (m_ready[gi]),
                .ov_pt     (pt[gi])
            );
        end
    endgenerate

    function automatic int rounds_of(input int u);
        return (u == 0) ? 1 : 25;
    endfunction

    // Forward cipher model: AddRoundKey, SubColumn, ShiftRow (rotl 0/1/12/13).
    function automatic logic [63:0] sub_column(input logic [63:0] s);
        logic [63:0] r;
        logic [3:0]  n;
        logic [3:0]  m;
        r = '0;
        for (int i = 0; i < 16; i++) begin
            n = {s[48+i], s[32+i], s[16+i], s[i]};
            m = SBOX[n];
            r[i]    = m[0];
            r[16+i] = m[1];
            r[32+i] = m[2];
            r[48+i] = m[3];
        end
        return r;
    endfunction

    function automatic logic [15:0] rotl(input logic [15:0] x, input int k);
        logic [31:0] d;
        d = {x, x} << k;
        return d[31:16];
    endfunction

    function automatic logic [63:0] shift_row(input logic [63:0] s);
        return {rotl(s[63:48], 13), rotl(s[47:32], 12), rotl(s[31:16], 1), s[15:0]};
    endfunction

    function automatic logic [63:0] encrypt(input int u, input logic [63:0] p);
        logic [63:0] s;
        int r_cnt;
        r_cnt = rounds_of(u);
        s = p;
        for (int r = 0; r < r_cnt; r++) s = shift_row(sub_column(s ^ keys[u][r]));
        return s ^ keys[u][r_cnt];
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called 1 time unit after a rising edge with the unit idle.
    task automatic run_dec(input int u, input logic [63:0] c, input int bp, output logic [63:0] res);
        int n;
        int r_cnt;
        r_cnt = rounds_of(u);
        chk("accept_ready", 64'(s_ready[u]), 64'd1);
        chk("accept_idx", 64'(rk_idx[u]), 64'(r_cnt));
        s_valid[u] = 1'b1;
        ct[u] = c;
        @(posedge clk); #1;
        s_valid[u] = 1'b0;
        chk("busy_ready", 64'(s_ready[u]), 64'd0);
        n = 0;
        while (!m_valid[u] && n < 100) begin
            chk("round_idx", 64'(rk_idx[u]), 64'(r_cnt - 1 - n));
            @(posedge clk); #1;
            n++;
        end
        chk("latency", 64'(n), 64'(r_cnt));
        res = pt[u];
        for (int k = 0; k < bp; k++) begin
            s_valid[u] = 1'b1;
            ct[u] = ~c;
            chk("bp_valid", 64'(m_valid[u]), 64'd1);
            chk("bp_pt", pt[u], res);
            chk("bp_ready", 64'(s_ready[u]), 64'd0);
            chk("bp_idx", 64'(rk_idx[u]), 64'd0);
            @(posedge clk); #1;
        end
        s_valid[u] = 1'b0;
        m_ready[u] = 1'b1;
        @(posedge clk); #1;
        m_ready[u] = 1'b0;
        chk("post_valid", 64'(m_valid[u]), 64'd0);
        chk("post_ready", 64'(s_ready[u]), 64'd1);
        chk("pt_hold", pt[u], res);
        $display("[TB] unit %0d ct=%h pt=%h latency=%0d bp=%0d", u, c, res, n, bp);
    endtask

    task automatic wait_idx12(input int u);
        int n;
        n = 0;
        while (rk_idx[u] != IDX_W'(12) && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("reach_cnt12", 64'(rk_idx[u]), 64'd12);
    endtask

    typedef struct {
        logic [63:0] ct;
        logic [63:0] k1;
        logic [63:0] k0;
        logic [63:0] pt;
    } vec_t;

    initial begin
        vec_t        vecs [4];
        logic [63:0] res;
        logic [63:0] p;
        logic [63:0] c;

        vecs[0] = '{ct: 64'h0, k1: 64'h0, k0: 64'h0, pt: 64'hFFFF_0000_0000_FFFF};
        vecs[1] = '{ct: 64'h0, k1: 64'h0, k0: 64'hFFFF_0000_0000_FFFF, pt: 64'h0};
        vecs[2] = '{ct: 64'hFFFF_FFFF_FFFF_FFFF, k1: 64'h0, k0: 64'h0, pt: 64'hFFFF_FFFF_0000_FFFF};
        vecs[3] = '{ct: 64'h0, k1: 64'hFFFF_FFFF_FFFF_FFFF, k0: 64'h0, pt: 64'hFFFF_FFFF_0000_FFFF};

        rst_n = 1'b0;
        for (int u = 0; u < 2; u++) begin
            s_valid[u] = 1'b0;
            m_ready[u] = 1'b0;
            ct[u] = '0;
`ifdef RECT_DEC_FLUSH_EN
            flush[u] = 1'b0;
`endif
            for (int k = 0; k < 32; k++) keys[u][k] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int u = 0; u < 2; u++) begin
            chk("rst_ready", 64'(s_ready[u]), 64'd1);
            chk("rst_valid", 64'(m_valid[u]), 64'd0);
            chk("rst_pt", pt[u], 64'h0);
            chk("rst_idx", 64'(rk_idx[u]), 64'(rounds_of(u)));
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Fixed single-round vectors.
        for (int i = 0; i < 4; i++) begin
            keys[0][1] = vecs[i].k1;
            keys[0][0] = vecs[i].k0;
            run_dec(0, vecs[i].ct, 0, res);
            chk("vec_pt", res, vecs[i].pt);
        end

        // Randomised round trips against the forward model.
        for (int t = 0; t < 6; t++) begin
            keys[0][0] = {$urandom, $urandom};
            keys[0][1] = {$urandom, $urandom};
            p = {$urandom, $urandom};
            c = encrypt(0, p);
            run_dec(0, c, int'($urandom_range(0, 2)), res);
            chk("rand1_pt", res, p);
        end
        for (int t = 0; t < 6; t++) begin
            for (int k = 0; k <= 25; k++) keys[1][k] = {$urandom, $urandom};
            p = {$urandom, $urandom};
            c = encrypt(1, p);
            run_dec(1, c, (t == 2) ? 10 : int'($urandom_range(0, 3)), res);
            chk("rand25_pt", res, p);
        end

        // Asynchronous reset in the middle of a 25-round operation.
        p = {$urandom, $urandom};
        c = encrypt(1, p);
        s_valid[1] = 1'b1;
        ct[1] = c;
        @(posedge clk); #1;
        s_valid[1] = 1'b0;
        wait_idx12(1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ready", 64'(s_ready[1]), 64'd1);
        chk("mid_rst_valid", 64'(m_valid[1]), 64'd0);
        chk("mid_rst_pt", pt[1], 64'h0);
        chk("mid_rst_idx", 64'(rk_idx[1]), 64'd25);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        p = {$urandom, $urandom};
        c = encrypt(1, p);
        run_dec(1, c, 1, res);
        chk("after_rst_pt", res, p);

`ifdef RECT_DEC_FLUSH_EN
        begin
            int pulses;
            c = encrypt(1, {$urandom, $urandom});
            s_valid[1] = 1'b1;
            ct[1] = c;
            @(posedge clk); #1;
            s_valid[1] = 1'b0;
            wait_idx12(1);
            flush[1] = 1'b1;
            @(posedge clk); #1;
            flush[1] = 1'b0;
            chk("flush_ready", 64'(s_ready[1]), 64'd1);
            chk("flush_idx", 64'(rk_idx[1]), 64'd25);
            pulses = 0;
            for (int k = 0; k < 30; k++) begin
                if (m_valid[1]) pulses++;
                @(posedge clk); #1;
            end
            chk("flush_no_valid", 64'(pulses), 64'd0);
            chk("flush_pt_kept", pt[1], res);
            p = {$urandom, $urandom};
            c = encrypt(1, p);
            run_dec(1, c, 0, res);
            chk("after_flush_pt", res, p);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, %0d tests run", tests);
        $fatal(1, "timeout");
    end

endmodule
